debug_prog_loader: RTL and testbench
====================================

Name: debug_prog_loader

Overview:
Parametrised UART-fed program loader and run-control front end for the pipeline debugger. It pops bytes from the UART RX FIFO and decodes command bytes. On a load command it takes a multi-byte instruction count, assembles INST_SZ-bit words from the byte stream (selectable byte order) and writes them to program memory at incrementing addresses. It then verifies an XOR checksum and supervises inter-byte timeout. It also decodes step, run and halt commands for the pipeline.

Parameters:
DBIT, 8, UART data byte width; fixed 8, other values unsupported
INST_SZ, 32, instruction width; must be a multiple of 8
PC, 32, program memory address width
SIZE_BYTES, 1, number of count bytes following CMD_LOAD; sent LSB-first
MAX_INST, 64, maximum instruction count accepted
BASE_ADDR, 0, first program memory byte address
BIG_ENDIAN, 0, 0 = first byte of a word is bits [7:0]; 1 = first byte is MSB
TIMEOUT_CLKS, 200000, idle clocks allowed between bytes during a load
CMD_LOAD / CMD_STEP / CMD_RUN / CMD_HALT, 8'hFF / 8'h01 / 8'h02 / 8'h03, command codes

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_rx_empty  in  1  RX FIFO empty
i_rx_data  in  DBIT  RX FIFO head byte, first-word-fall-through, valid when !i_rx_empty
o_rd_uart  out  1  pop pulse to RX FIFO
o_instruction  out  INST_SZ  assembled instruction
o_program_mem_addr  out  PC  write byte address
o_mem_w  out  1  program memory write strobe, 1 cycle
o_load_done  out  1  last load finished with a good checksum
o_load_err  out  1  last load failed (checksum, oversize or timeout)
o_run  out  1  continuous-run enable
o_step  out  1  single-step pulse, 1 cycle

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; o_program_mem_addr = BASE_ADDR; checksum, counters and byte index cleared.
- Byte acceptance: in every state except DONE/ERR, when !i_rx_empty, assert o_rd_uart combinationally and consume i_rx_data on that edge. At most 1 byte per cycle. Never pop when i_rx_empty.
- IDLE:
  - CMD_LOAD: clear o_load_done, o_load_err, o_run, checksum; set addr = BASE_ADDR; go to SIZE.
  - CMD_STEP: o_step = 1 for next cycle only; ignored while o_run = 1.
  - CMD_RUN: o_run <= 1.
  - CMD_HALT: o_run <= 0.
  - Any other byte: popped and discarded.
- SIZE: collect SIZE_BYTES bytes LSB-first into count; XOR each into checksum. After the last byte:
  - count > MAX_INST: go to ERR.
  - count = 0: go to CHECK.
  - otherwise: go to DATA.
- DATA: place each byte into the word register per BIG_ENDIAN; XOR into checksum. On the INST_SZ/8-th byte:
  - next cycle o_instruction holds the word, o_mem_w = 1, o_program_mem_addr holds the current address.
  - the cycle after, address += INST_SZ/8 and the words-remaining count decrements.
  - When the last word is written, go to CHECK.
  - A byte arriving during the o_mem_w cycle is accepted normally.
- CHECK: the next byte is compared with the checksum. Match: go to DONE. Mismatch: go to ERR. Words already written are not rolled back.
- DONE: o_load_done <= 1, return to IDLE (1 cycle, no pop).
- ERR: o_load_err <= 1, return to IDLE (1 cycle, no pop).
- Timeout: in SIZE, DATA and CHECK an idle counter resets on each popped byte. At TIMEOUT_CLKS consecutive empty cycles go to ERR; a partial word is discarded with no write.
- Address arithmetic wraps modulo 2^PC.
- o_instruction holds the last written word until the next write.

Test Plan:
- Defaults: bytes FF 02 11 22 33 44 55 66 77 88 8A -> o_mem_w twice: 0x44332211 @0, 0x88776655 @4; o_load_done = 1, o_load_err = 0; no further pops.
- Same stream with checksum 0x8B -> both writes occur, then o_load_err = 1, o_load_done = 0. A following FF 00 00 -> o_load_done = 1, zero writes.
- BIG_ENDIAN = 1, FF 01 0A 0B 0C 0D 0D -> single write 0x0A0B0C0D @BASE_ADDR.
- FF 41 (65 > MAX_INST) -> o_load_err = 1 immediately after the size byte, no writes. Then 01 -> one o_step pulse.
- FF 01 11 22, then FIFO empty for TIMEOUT_CLKS cycles -> o_load_err = 1, no o_mem_w. Then i_reset asserted mid-way through a second load -> all outputs 0 and addr = BASE_ADDR within the same cycle.
- 02 then 01 then 03 then 01 -> o_run rises and the first step is ignored. After HALT, o_run falls and exactly one o_step pulse follows. 5A interleaved is discarded.

Source files
------------

// File: rtl/debug_prog_loader.sv
// UART-fed program loader and run control: decodes command bytes, loads instruction words into program memory.
// Latency: o_mem_w asserts one cycle after a word's last byte is popped; address advances the cycle after that.
// Backpressure: pops one byte per cycle whenever the RX FIFO is non-empty, except in the DONE/ERR cycle.
module debug_prog_loader #(
  parameter int DBIT                = 8,
  parameter int INST_SZ             = 32,
  parameter int PC                  = 32,
  parameter int SIZE_BYTES          = 1,
  parameter int MAX_INST            = 64,
  parameter logic [PC-1:0] BASE_ADDR = '0,
  parameter int BIG_ENDIAN          = 0,
  parameter int TIMEOUT_CLKS        = 200000,
  parameter logic [7:0] CMD_LOAD    = 8'hFF,
  parameter logic [7:0] CMD_STEP    = 8'h01,
  parameter logic [7:0] CMD_RUN     = 8'h02,
  parameter logic [7:0] CMD_HALT    = 8'h03
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_empty,
  input  logic [DBIT-1:0]    i_rx_data,
  output logic               o_rd_uart,
  output logic [INST_SZ-1:0] o_instruction,
  output logic [PC-1:0]      o_program_mem_addr,
  output logic               o_mem_w,
  output logic               o_load_done,
  output logic               o_load_err,
  output logic               o_run,
  output logic               o_step
);
  localparam int NB  = INST_SZ / 8;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW  = SIZE_BYTES * 8;
  localparam int SIW = (SIZE_BYTES > 1) ? $clog2(SIZE_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SIZE  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]         r_state;
  logic [7:0]         r_chk;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      r_remaining;
  logic [INST_SZ-1:0] r_word;
  logic [BIW-1:0]     r_bidx;
  logic [SIW-1:0]     r_sidx;
  logic [TW-1:0]      r_idle;

  logic               w_pop;
  logic               w_loading;
  logic [INST_SZ-1:0] w_word_ins;
  logic [CW-1:0]      w_count_ins;
  logic [CW-1:0]      w_rem_eff;
  logic               w_last_word;

  assign w_loading = (r_state == S_SIZE) || (r_state == S_DATA) || (r_state == S_CHECK);
  assign w_pop     = !i_reset && !i_rx_empty && (w_loading || (r_state == S_IDLE));
  assign o_rd_uart = w_pop;

  // A word write still pending its address/count update must be discounted when spotting the last word.
  assign w_rem_eff   = r_remaining - (o_mem_w ? CW'(1) : CW'(0));
  assign w_last_word = (w_rem_eff == CW'(1));

  // Merge the head byte into the partial word and the partial count at the current byte index.
  always_comb begin
    w_word_ins  = r_word;
    w_count_ins = r_count;
    if (BIG_ENDIAN != 0) w_word_ins[(NB - 1 - int'(r_bidx)) * 8 +: 8] = i_rx_data[7:0];
    else                 w_word_ins[int'(r_bidx) * 8 +: 8]            = i_rx_data[7:0];
    w_count_ins[int'(r_sidx) * 8 +: 8] = i_rx_data[7:0];
  end

  // Command decode, load sequencing, word writes, checksum and inter-byte timeout.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state            <= S_IDLE;
      r_chk              <= '0;
      r_count            <= '0;
      r_remaining        <= '0;
      r_word             <= '0;
      r_bidx             <= '0;
      r_sidx             <= '0;
      r_idle             <= '0;
      o_instruction      <= '0;
      o_program_mem_addr <= BASE_ADDR;
      o_mem_w            <= 1'b0;
      o_load_done        <= 1'b0;
      o_load_err         <= 1'b0;
      o_run              <= 1'b0;
      o_step             <= 1'b0;
    end else begin
      o_mem_w <= 1'b0;
      o_step  <= 1'b0;
      if (o_mem_w) begin
        o_program_mem_addr <= o_program_mem_addr + PC'(NB);
        r_remaining        <= r_remaining - CW'(1);
      end
      if (w_loading) begin
        if (w_pop) begin
          r_idle <= '0;
        end else if (r_idle == TW'(TIMEOUT_CLKS - 1)) begin
          r_idle  <= '0;
          r_state <= S_ERR;
        end else begin
          r_idle <= r_idle + TW'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (i_rx_data[7:0] == CMD_LOAD) begin
              o_load_done        <= 1'b0;
              o_load_err         <= 1'b0;
              o_run              <= 1'b0;
              r_chk              <= '0;
              r_count            <= '0;
              r_sidx             <= '0;
              r_bidx             <= '0;
              r_idle             <= '0;
              o_program_mem_addr <= BASE_ADDR;
              r_state            <= S_SIZE;
            end else if (i_rx_data[7:0] == CMD_STEP) begin
              if (!o_run) o_step <= 1'b1;
            end else if (i_rx_data[7:0] == CMD_RUN) begin
              o_run <= 1'b1;
            end else if (i_rx_data[7:0] == CMD_HALT) begin
              o_run <= 1'b0;
            end
          end
        end
        S_SIZE: begin
          if (w_pop) begin
            r_chk   <= r_chk ^ i_rx_data[7:0];
            r_count <= w_count_ins;
            if (r_sidx == SIW'(SIZE_BYTES - 1)) begin
              r_sidx      <= '0;
              r_remaining <= w_count_ins;
              if (w_count_ins > CW'(MAX_INST)) r_state <= S_ERR;
              else if (w_count_ins == '0)      r_state <= S_CHECK;
              else                             r_state <= S_DATA;
            end else begin
              r_sidx <= r_sidx + SIW'(1);
            end
          end
        end
        S_DATA: begin
          if (w_pop) begin
            r_chk  <= r_chk ^ i_rx_data[7:0];
            r_word <= w_word_ins;
            if (r_bidx == BIW'(NB - 1)) begin
              r_bidx        <= '0;
              o_instruction <= w_word_ins;
              o_mem_w       <= 1'b1;
              if (w_last_word) r_state <= S_CHECK;
            end else begin
              r_bidx <= r_bidx + BIW'(1);
            end
          end
        end
        S_CHECK: begin
          if (w_pop) r_state <= (i_rx_data[7:0] == r_chk) ? S_DONE : S_ERR;
        end
        S_DONE: begin
          o_load_done <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_ERR: begin
          o_load_err <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_prog_loader.sv
// Directed bench for debug_prog_loader: little-endian instance (a) and big-endian instance (b).
// Byte FIFOs are modelled as queues; expected writes are queued in a scoreboard and popped on o_mem_w.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_debug_prog_loader;
  localparam int TOUT = 100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        empty_a, empty_b;
  logic [7:0]  data_a, data_b;
  logic        rd_a, rd_b, memw_a, memw_b;
  logic        done_a, done_b, err_a, err_b, run_a, run_b, step_a, step_b;
  logic [31:0] inst_a, inst_b, addr_a, addr_b;

  logic [7:0] fq_a[$];
  logic [7:0] fq_b[$];
  wr_t        sb_a[$];
  wr_t        sb_b[$];
  bit         pend_a, pend_b;
  int         n_checks = 0;
  int         n_errors = 0;
  int         pops_a = 0, wr_a = 0, wr_b = 0, steps_a = 0;
  int         wr0, st0;

  debug_prog_loader #(.TIMEOUT_CLKS(TOUT)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_rx_empty(empty_a), .i_rx_data(data_a),
    .o_rd_uart(rd_a), .o_instruction(inst_a), .o_program_mem_addr(addr_a), .o_mem_w(memw_a),
    .o_load_done(done_a), .o_load_err(err_a), .o_run(run_a), .o_step(step_a));

  debug_prog_loader #(.TIMEOUT_CLKS(TOUT), .BIG_ENDIAN(1)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_rx_empty(empty_b), .i_rx_data(data_b),
    .o_rd_uart(rd_b), .o_instruction(inst_b), .o_program_mem_addr(addr_b), .o_mem_w(memw_b),
    .o_load_done(done_b), .o_load_err(err_b), .o_run(run_b), .o_step(step_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model for instance a: pop what the DUT took on the previous rising edge, then present the new head.
  initial begin
    pend_a = 1'b0; empty_a = 1'b1; data_a = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        fq_a.delete(); pend_a = 1'b0;
      end else if (pend_a && fq_a.size() != 0) begin
        void'(fq_a.pop_front()); pops_a++;
      end
      empty_a = (fq_a.size() == 0);
      data_a  = empty_a ? 8'h00 : fq_a[0];
      #1;
      pend_a = rd_a;
      if (rd_a) chk("pop_when_empty_a", 64'(empty_a), 64'd0);
    end
  end

  // FIFO model for instance b.
  initial begin
    pend_b = 1'b0; empty_b = 1'b1; data_b = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        fq_b.delete(); pend_b = 1'b0;
      end else if (pend_b && fq_b.size() != 0) begin
        void'(fq_b.pop_front());
      end
      empty_b = (fq_b.size() == 0);
      data_b  = empty_b ? 8'h00 : fq_b[0];
      #1;
      pend_b = rd_b;
      if (rd_b) chk("pop_when_empty_b", 64'(empty_b), 64'd0);
    end
  end

  // Write and step monitors: every o_mem_w must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst && step_a) steps_a++;
    if (!rst && memw_a) begin
      wr_a++;
      n_checks++;
      assert (sb_a.size() != 0) else begin
        n_errors++;
        $error("FAIL wr_a_unexpected observed addr=%0h data=%0h expected no write", addr_a, inst_a);
      end
      if (sb_a.size() != 0) chk("wr_a", {addr_a, inst_a}, sb_a.pop_front());
    end
    if (!rst && memw_b) begin
      wr_b++;
      n_checks++;
      assert (sb_b.size() != 0) else begin
        n_errors++;
        $error("FAIL wr_b_unexpected observed addr=%0h data=%0h expected no write", addr_b, inst_b);
      end
      if (sb_b.size() != 0) chk("wr_b", {addr_b, inst_b}, sb_b.pop_front());
    end
  end

  task automatic push_a(input logic [7:0] b);
    fq_a.push_back(b);
  endtask

  task automatic drain_a(input int lim);
    int n = 0;
    while ((fq_a.size() != 0 || pend_a) && n < lim) begin
      @(negedge clk); #3; n++;
    end
    chk("drain_a_bound", 64'(n < lim), 64'd1);
    repeat (4) @(negedge clk);
    #3;
  endtask

  task automatic drain_b(input int lim);
    int n = 0;
    while ((fq_b.size() != 0 || pend_b) && n < lim) begin
      @(negedge clk); #3; n++;
    end
    chk("drain_b_bound", 64'(n < lim), 64'd1);
    repeat (4) @(negedge clk);
    #3;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    #12;
    chk("reset_outs_a", {rd_a, memw_a, done_a, err_a, run_a, step_a, inst_a}, 64'd0);
    chk("reset_addr_a", 64'(addr_a), 64'd0);
    chk("reset_outs_b", {rd_b, memw_b, done_b, err_b, run_b, step_b, inst_b}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Two-word load, good checksum (02^11^22^33^44^55^66^77^88 = 8A).
    pops_a = 0;
    sb_a.push_back('{32'h0, 32'h44332211});
    sb_a.push_back('{32'h4, 32'h88776655});
    foreach (fq_a[i]) ;
    push_a(8'hFF); push_a(8'h02);
    for (int i = 1; i <= 8; i++) push_a(8'(i * 8'h11));
    push_a(8'h8A);
    drain_a(100);
    repeat (5) @(negedge clk);
    chk("t1_done", 64'(done_a), 64'd1);
    chk("t1_err", 64'(err_a), 64'd0);
    chk("t1_writes", 64'(wr_a), 64'd2);
    chk("t1_sb_empty", 64'(sb_a.size()), 64'd0);
    chk("t1_no_extra_pops", 64'(pops_a), 64'd11);
    chk("t1_rd_idle", 64'(rd_a), 64'd0);

    // Same stream, bad checksum: writes still happen, then error.
    sb_a.push_back('{32'h0, 32'h44332211});
    sb_a.push_back('{32'h4, 32'h88776655});
    push_a(8'hFF); push_a(8'h02);
    for (int i = 1; i <= 8; i++) push_a(8'(i * 8'h11));
    push_a(8'h8B);
    drain_a(100);
    chk("t2_err", 64'(err_a), 64'd1);
    chk("t2_done", 64'(done_a), 64'd0);
    chk("t2_writes", 64'(wr_a), 64'd4);
    chk("t2_hold_inst", 64'(inst_a), 64'h88776655);

    // Zero-length load: checksum is just the size byte.
    wr0 = wr_a;
    push_a(8'hFF); push_a(8'h00); push_a(8'h00);
    drain_a(50);
    chk("t3_done", 64'(done_a), 64'd1);
    chk("t3_err", 64'(err_a), 64'd0);
    chk("t3_no_writes", 64'(wr_a - wr0), 64'd0);

    // Oversize count (65 > 64) errors straight after the size byte; then a step.
    wr0 = wr_a; st0 = steps_a;
    push_a(8'hFF); push_a(8'h41);
    drain_a(50);
    chk("t4_err", 64'(err_a), 64'd1);
    chk("t4_no_writes", 64'(wr_a - wr0), 64'd0);
    push_a(8'h01);
    drain_a(50);
    chk("t4_step_once", 64'(steps_a - st0), 64'd1);

    // Timeout with a partial word: not yet at TOUT-10 idle cycles, error after TOUT.
    wr0 = wr_a;
    push_a(8'hFF); push_a(8'h01); push_a(8'h11); push_a(8'h22);
    drain_a(50);
    repeat (TOUT - 20) @(negedge clk);
    chk("t5_no_early_timeout", 64'(err_a), 64'd0);
    repeat (30) @(negedge clk);
    chk("t5_timeout_err", 64'(err_a), 64'd1);
    chk("t5_no_writes", 64'(wr_a - wr0), 64'd0);

    // Async reset mid-way through a second load.
    push_a(8'hFF); push_a(8'h02); push_a(8'h11); push_a(8'h22); push_a(8'h33);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_outs", {rd_a, memw_a, done_a, err_a, run_a, step_a, inst_a}, 64'd0);
    chk("t5_rst_addr", 64'(addr_a), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Run control: step ignored while running; junk byte discarded; step honoured after halt.
    st0 = steps_a;
    push_a(8'h02);
    drain_a(20);
    chk("t6_run_on", 64'(run_a), 64'd1);
    push_a(8'h01); push_a(8'h5A);
    drain_a(20);
    chk("t6_step_ignored", 64'(steps_a - st0), 64'd0);
    chk("t6_run_held", 64'(run_a), 64'd1);
    push_a(8'h03);
    drain_a(20);
    chk("t6_run_off", 64'(run_a), 64'd0);
    push_a(8'h5A); push_a(8'h01);
    drain_a(20);
    chk("t6_one_step", 64'(steps_a - st0), 64'd1);

    // Big-endian single word; trailing 0D mismatches the checksum (01^0A^0B^0C^0D = 01).
    sb_b.push_back('{32'h0, 32'h0A0B0C0D});
    fq_b.push_back(8'hFF); fq_b.push_back(8'h01);
    fq_b.push_back(8'h0A); fq_b.push_back(8'h0B); fq_b.push_back(8'h0C); fq_b.push_back(8'h0D);
    fq_b.push_back(8'h0D);
    drain_b(50);
    chk("t7_be_writes", 64'(wr_b), 64'd1);
    chk("t7_be_sb_empty", 64'(sb_b.size()), 64'd0);
    chk("t7_be_err", 64'(err_b), 64'd1);
    chk("t7_be_done", 64'(done_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
